serializer7_tx: RTL
===================

// Module: serializer7_tx
// PURPOSE
//  Parallel-to-serial source feeding the 7-bit serial-in/parallel-out shift register stage.
//  - Accepts a W-bit word on a valid/ready handshake.
//  - Emits the word LSB-first on oSR, with a one-cycle shift strobe oENABLE per bit.
//  - Drive oSR/oENABLE straight into the downstream register's iSR/iENABLE (same clock).
//  - After W strobes the downstream parallel output equals the accepted word.
// PARAMETERS
//  W    7  word width in bits; legal range 2..16; downstream register width must match
//  DIV  1  bit period in iCLK cycles; DIV>=1; DIV==0 is a fatal elaboration error
// PORTS
//  iCLK     in   1  clock, rising edge
//  iRST_n   in   1  asynchronous reset, active low
//  iDATA    in   W  word to send; sampled only on handshake
//  iVALID   in   1  iDATA valid
//  oREADY   out  1  block can accept a word; handshake = iVALID & oREADY at posedge
//  oSR      out  1  serial data bit, LSB first
//  oENABLE  out  1  one-cycle shift strobe; oSR is valid whenever oENABLE=1
//  oLAST    out  1  high together with the W-th (final) oENABLE of a word
//  oBUSY    out  1  word in flight (state SHIFT)
// BEHAVIOUR
//  - Registers: state {IDLE,SHIFT}; shreg[W-1:0]; bitcnt 0..W-1; divcnt 0..DIV-1.
//  - All outputs are decoded from registers; there are no input-to-output combinational paths.
//  - Reset (iRST_n=0, asynchronous): state=IDLE, shreg=0, bitcnt=0, divcnt=0.
//    Outputs during reset: oSR=0, oENABLE=0, oLAST=0, oBUSY=0, oREADY=1.
//  - IDLE:
//    - oREADY=1, oENABLE=0, oSR=0.
//    - On handshake: shreg<=iDATA, bitcnt<=0, divcnt<=DIV-1, state<=SHIFT.
//  - SHIFT:
//    - oBUSY=1; oSR=shreg[0].
//    - tick = (divcnt==0); oENABLE=tick.
//    - divcnt decrements each cycle and reloads DIV-1 on tick.
//    - On tick: shreg<=shreg>>1 (MSB filled with 0), bitcnt<=bitcnt+1.
//    - oLAST = tick & (bitcnt==W-1). On that cycle: state<=IDLE, bitcnt<=0.
//  - Latency: the first oENABLE comes DIV cycles after the handshake cycle.
//    - Strobes are spaced DIV cycles apart.
//    - With DIV=1, the 7 strobes fall on the 7 consecutive cycles after the handshake.
//  - iVALID while oREADY=0 is ignored: no word is accepted or queued, and iDATA has no effect.
//  - Reset mid-word aborts the word immediately:
//    - No further oENABLE; no oLAST.
//    - Downstream holds a partial shift, and the downstream reset is responsible for it.
//  - bitcnt never exceeds W-1. divcnt wraps only through reload. No overflow states are reachable.
// CONFIGURATION
//  SERIALIZER7_B2B_EN (back-to-back mode)
//  - Defined:
//    - oREADY = IDLE | oLAST.
//    - A handshake on the oLAST cycle reloads shreg/bitcnt/divcnt and the block stays in SHIFT.
//    - Result: gapless streaming; with DIV=1, 14 consecutive strobes for 2 words.
//  - Undefined:
//    - oREADY = IDLE only.
//    - At least one IDLE cycle separates words, so strobe gap >= DIV+1 cycles.
// TESTING
//  T1 Reset: hold iRST_n=0 mid-SHIFT, async assert -> same cycle oENABLE=0, oBUSY=0, oREADY=1; no oLAST.
//  T2 DIV=1, send 7'h55 -> oENABLE high cycles 1..7 after handshake, oSR=1,0,1,0,1,0,1;
//     oLAST on 7th; downstream oPR=7'h55.
//  T3 DIV=3, send 7'h01 -> strobes at cycles 3,6,..,21; oSR=1 then six 0s; oBUSY high 21 cycles.
//  T4 Ignore busy: send 7'h7F, then pulse iVALID with 7'h00 at bit 3
//     -> stream unaffected; downstream=7'h7F; second word lost.
//  T5 Back-to-back (macro on, DIV=1): words 7'h12, 7'h6D with iVALID held
//     -> 14 contiguous strobes, oLAST at 7 and 14.
//     Macro off: 1-cycle gap after strobe 7.
//  T6 Random: 1000 words, random DIV in 1..4 and random iVALID
//     -> scoreboard: downstream oPR at each oLAST+1 equals the accepted word.

Source files
------------

// File: rtl/serializer7_tx.sv
// serializer7_tx: parallel-to-serial source for a W-bit SIPO shift register stage.
// Takes one word per valid/ready handshake. It then sends the word LSB-first on oSR,
// with one oENABLE strobe every DIV cycles. oLAST marks the final strobe.
// Latency: the first strobe comes DIV cycles after the handshake. oREADY is low
// while a word is in flight. In that time iVALID is ignored and the word is dropped, not queued.
// Ports: iCLK, iRST_n (async, active low) | iDATA[W-1:0], iVALID, oREADY |
//        oSR, oENABLE, oLAST, oBUSY.
// Option: define SERIALIZER7_B2B_EN to raise oREADY on the oLAST cycle. A word
//         accepted on that cycle follows the previous one with no gap.
module serializer7_tx #(
   parameter int W   = 7,
   parameter int DIV = 1
) (
   input  logic         iCLK,
   input  logic         iRST_n,
   input  logic [W-1:0] iDATA,
   input  logic         iVALID,
   output logic         oREADY,
   output logic         oSR,
   output logic         oENABLE,
   output logic         oLAST,
   output logic         oBUSY
);

   localparam int BW = (W > 2) ? $clog2(W) : 1;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

   generate
      if (W < 2 || W > 16) begin : g_bad_w
         $fatal(1, "serializer7_tx: W must be in 2..16");
      end
      if (DIV < 1) begin : g_bad_div
         $fatal(1, "serializer7_tx: DIV must be >= 1");
      end
   endgenerate

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   shreg_q, shreg_d;
   logic [BW-1:0]  bitcnt_q, bitcnt_d;
   logic [DW-1:0]  divcnt_q, divcnt_d;

   logic tick;
   logic last;
   logic ready;
   logic hs;

   always_comb begin
      tick  = (state_q == SHIFT) && (divcnt_q == '0);
      last  = tick && (bitcnt_q == BIT_LAST);
`ifdef SERIALIZER7_B2B_EN
      ready = (state_q == IDLE) || last;
`else
      ready = (state_q == IDLE);
`endif
      hs    = iVALID && ready;

      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      divcnt_d = divcnt_q;

      case (state_q)
         IDLE: begin
            if (hs) begin
               shreg_d  = iDATA;
               bitcnt_d = '0;
               divcnt_d = DIV_LAST;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            if (tick) begin
               shreg_d  = shreg_q >> 1;
               bitcnt_d = bitcnt_q + BW'(1);
               divcnt_d = DIV_LAST;
               if (last) begin
                  bitcnt_d = '0;
                  state_d  = IDLE;
                  // A word taken on the final strobe reloads the shifter, so the next strobe falls DIV cycles later.
                  if (hs) begin
                     shreg_d = iDATA;
                     state_d = SHIFT;
                  end
               end
            end else begin
               divcnt_d = divcnt_q - DW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRST_n) begin
      if (!iRST_n) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         divcnt_q <= '0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
         divcnt_q <= divcnt_d;
      end
   end

   // Outputs are decoded only from state. An asynchronous reset therefore silences them at once.
   assign oREADY  = ready;
   assign oSR     = (state_q == SHIFT) ? shreg_q[0] : 1'b0;
   assign oENABLE = tick;
   assign oLAST   = last;
   assign oBUSY   = (state_q == SHIFT);

endmodule
